// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type and line/beat sizing helper for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} arb_state_t;
  function automatic int beats_f(int line_w, int burst_w);
    return line_w / burst_w;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: client-side line ports and memory-side beat bus of the arbiter
interface mem_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W = 32
);
  logic [NUM_PORTS-1:0] port_read, port_write, port_resp;
  logic [NUM_PORTS*ADDR_W-1:0] port_addr;
  logic [NUM_PORTS*LINE_W-1:0] port_wline;
  logic [LINE_W-1:0] port_rline;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_read, mem_write, mem_resp, busy;
  logic [BURST_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input port_read, port_write, port_addr, port_wline, mem_rdata, mem_resp,
    output port_rline, port_resp, mem_addr, mem_read, mem_write, mem_wdata, busy
  );
  modport master (
    output port_read, port_write, port_addr, port_wline, mem_rdata, mem_resp,
    input port_rline, port_resp, mem_addr, mem_read, mem_write, mem_wdata, busy
  );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: picks the first requester at or after ptr (round-robin) or from index 0 (fixed priority)
module rr_picker #(
  parameter int N = 2,
  parameter int RR_MODE = 1
) (
  input logic [N-1:0] req_i,
  input logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] base;
  assign base = (RR_MODE != 0) ? ptr_i : '0;
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[(int'(base) + i) % N]) idx_o = IW'((int'(base) + i) % N);
    gnt_o = |req_i ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates cache-line reads/writes from NUM_PORTS clients onto a beat-wise memory bus
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W = 32,
  parameter int RR_MODE = 1
) (
  input logic clk,
  input logic reset_n,
  mem_arbiter_if.slave bus
);
  localparam int BEATS = beats_f(LINE_W, BURST_W);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int IW = $clog2(NUM_PORTS);
  if (LINE_W % BURST_W != 0) begin : g_bad_width
    $error("LINE_W must be an integer multiple of BURST_W");
  end
  arb_state_t state_q;
  logic [BW-1:0] beat_q;
  logic [IW-1:0] rr_ptr_q, grant_q, pick_idx;
  logic [NUM_PORTS-1:0] req, pick_gnt, gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wline_q, rline_q;
  logic last;
  assign req = bus.port_read | bus.port_write;
  assign last = beat_q == BW'(BEATS - 1);
  rr_picker #(.N(NUM_PORTS), .RR_MODE(RR_MODE)) u_pick (
    .req_i(req),
    .ptr_i(rr_ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx)
  );
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= IDLE;
      beat_q <= '0;
      rr_ptr_q <= '0;
      grant_q <= '0;
      gnt_q <= '0;
      addr_q <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          grant_q <= pick_idx;
          gnt_q <= pick_gnt;
          addr_q <= bus.port_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          wline_q <= bus.port_wline[int'(pick_idx)*LINE_W +: LINE_W];
          state_q <= bus.port_write[pick_idx] ? WRITE : READ;
        end
        READ, WRITE: if (bus.mem_resp) begin
          if (state_q == READ) rline_q[int'(beat_q)*BURST_W +: BURST_W] <= bus.mem_rdata;
          beat_q <= last ? '0 : beat_q + 1'b1;
          if (last) state_q <= RESP;
        end
        RESP: begin
          rr_ptr_q <= (grant_q == IW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.mem_read = state_q == READ;
  assign bus.mem_write = state_q == WRITE;
  assign bus.mem_addr = (state_q == READ || state_q == WRITE) ? addr_q : '0;
  assign bus.mem_wdata = (state_q == WRITE) ? wline_q[int'(beat_q)*BURST_W +: BURST_W] : '0;
  assign bus.port_rline = rline_q;
  assign bus.port_resp = (state_q == RESP) ? gnt_q : '0;
  assign bus.busy = !reset_n && (state_q != IDLE || |req);
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of cache clients (2..8).
REQ-002 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-003 SHALL have parameter BURST_W, default 64, memory beat width; LINE_W SHALL be an integer multiple of BURST_W, and BEATS = LINE_W/BURST_W.
REQ-004 SHALL have parameter ADDR_W, default 32, address width.
REQ-005 SHALL have parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 reset_n  input  1  reset, asynchronous, active-high.
REQ-008 port_read  input  NUM_PORTS  per-client line read request.
REQ-009 port_write  input  NUM_PORTS  per-client line write request.
REQ-010 port_addr  input  NUM_PORTS*ADDR_W  per-client line address; client i occupies slice [i*ADDR_W +: ADDR_W].
REQ-011 port_wline  input  NUM_PORTS*LINE_W  per-client write line; client i occupies slice [i*LINE_W +: LINE_W].
REQ-012 port_rline  output  LINE_W  read line, shared by all clients.
REQ-013 port_resp  output  NUM_PORTS  one-hot completion strobe.
REQ-014 mem_addr  output  ADDR_W  memory address.
REQ-015 mem_read  output  1  memory read request.
REQ-016 mem_write  output  1  memory write request.
REQ-017 mem_wdata  output  BURST_W  write beat.
REQ-018 mem_rdata  input  BURST_W  read beat.
REQ-019 mem_resp  input  1  beat accepted/valid.
REQ-020 busy  output  1  high while any transaction is outstanding.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, READ, WRITE, RESP.
REQ-022 In IDLE, a request from client i means port_read[i] | port_write[i]; the grant SHALL be computed combinationally from these requests and registered on the leaving edge.
REQ-023 In fixed-priority mode the lowest requesting index SHALL win.
REQ-024 In round-robin mode the first requester at or after rr_ptr (wrapping modulo NUM_PORTS) SHALL win, and rr_ptr SHALL become grant+1 (mod NUM_PORTS) on exit from RESP.
REQ-025 On grant, the arbiter SHALL latch the client's address and, for writes, the full port_wline slice; later changes to either SHALL NOT affect the transfer.
REQ-026 If the granted client asserts both read and write, write SHALL win.
REQ-027 IDLE SHALL transition to WRITE or READ in the cycle after the request is seen; one-cycle grant latency.
REQ-028 In READ/WRITE, mem_read/mem_write SHALL stay high and mem_addr SHALL equal the latched address.
REQ-029 Beat counter beat (width clog2(BEATS)) SHALL increment on each mem_resp.
REQ-030 Read beat k SHALL be stored in line buffer bits [k*BURST_W +: BURST_W].
REQ-031 mem_wdata SHALL equal latched line bits [beat*BURST_W +: BURST_W].
REQ-032 mem_resp on beat BEATS-1 SHALL move the FSM to RESP and clear beat to 0.
REQ-033 RESP SHALL last exactly one cycle: port_resp[grant]=1, all other port_resp bits 0, next state IDLE.
REQ-034 port_rline SHALL be the line buffer, valid in RESP and held until the next read's first beat.
REQ-035 mem_resp SHALL be ignored in IDLE and RESP.
REQ-036 Deasserting a request mid-transfer SHALL NOT abort the transfer; the transfer completes and port_resp is still issued.
REQ-037 Clients SHALL drop requests in the cycle after port_resp; the arbiter does not re-arbitrate in RESP.
REQ-038 busy SHALL equal (state != IDLE) | (|port_read) | (|port_write).

Reset
REQ-039 While reset_n=1, the block SHALL immediately set state=IDLE, beat=0, rr_ptr=0, grant=0, and clear the line buffer and latched line/address.
REQ-040 While reset_n=1, all outputs SHALL be 0.
REQ-041 Reset asserted mid-burst SHALL abandon the transfer, and no port_resp SHALL be issued for it.

Structure
REQ-042 Package mem_arb_pkg SHALL hold the state enum arb_state_t and the function beats_f(LINE_W,BURST_W).
REQ-043 Grant selection SHALL live in sub-module rr_picker (parameters N and RR_MODE; inputs req, ptr; output one-hot gnt plus index).
REQ-044 Elaboration SHALL fail if LINE_W % BURST_W != 0.

Verification
REQ-045 Defaults; client1 read to 0x0000_1040; mem_rdata beats 0x11..,0x22..,0x33..,0x44.. with mem_resp one cycle each -> port_rline = {0x44..,0x33..,0x22..,0x11..}, port_resp=2'b10 for one cycle, 6 cycles after request.
REQ-046 Client0 write of line 0xA..B; port_wline changed after grant; mem_resp delayed 3 cycles per beat -> mem_wdata shows original beats in order 0..3, then port_resp=2'b01.
REQ-047 RR_MODE=1, NUM_PORTS=3, all clients request continuously -> grants 0,1,2,0; RR_MODE=0 under the same stimulus -> grants 0,0,0.
REQ-048 Client0 asserts read and write together -> mem_write=1 and mem_read stays 0 for the whole transfer.
REQ-049 reset_n pulsed after beat 2 of a read -> outputs 0 immediately; no port_resp; the next request completes normally with beat starting at 0.
REQ-050 LINE_W=512, BURST_W=128 -> 4 beats assembled correctly; mem_resp asserted in IDLE has no effect.
